pulse_measure: RTL and testbench
================================

PULSE_MEASURE -- requirements
Module: pulse_measure

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the bit width of the width/gap counters and outputs (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port d, input, 1, pulse train, synchronous to clk.
REQ-005 SHALL have port width, output, WIDTH, length in cycles of the last completed high pulse.
REQ-006 SHALL have port width_valid, output, 1, one-cycle strobe that width/width_ovf were updated.
REQ-007 SHALL have port width_ovf, output, 1, last width saturated.
REQ-008 SHALL have port gap, output, WIDTH, length in cycles of the last completed low interval between pulses.
REQ-009 SHALL have port gap_valid, output, 1, one-cycle strobe that gap/gap_ovf were updated.
REQ-010 SHALL have port gap_ovf, output, 1, last gap saturated.
REQ-011 SHALL have port pulses, output, 16, count of measured rising edges, wraps modulo 2^16.

Function
REQ-012 SHALL sample d on every clk edge; all outputs registered, updated on that same edge.
REQ-013 SHALL implement FSM states SYNC, LOW, HIGH.
REQ-014 SYNC: d=1 -> stay, no strobes; d=0 -> LOW, gap counter := 1, first flag := 1.
REQ-015 LOW, d=0: gap counter += 1, saturating at 2^WIDTH-1; gap overflow flag set on an attempted increment past the maximum.
REQ-016 LOW, d=1: -> HIGH; width counter := 1; pulses += 1; if first flag = 0, gap := gap counter, gap_ovf := flag, gap_valid := 1; first flag := 0.
REQ-017 HIGH, d=1: width counter += 1, saturating at 2^WIDTH-1 with width overflow flag.
REQ-018 HIGH, d=0: -> LOW; width := width counter, width_ovf := flag, width_valid := 1; gap counter := 1, gap overflow flag := 0.
REQ-019 width = exact count of consecutive high samples; gap = exact count of consecutive low samples.
REQ-020 Adjacent pulses with no low sample between them SHALL be measured as one merged pulse.
REQ-021 width_valid and gap_valid SHALL each be high for exactly one cycle per event; they are never both high in the same cycle.
REQ-022 width, gap, *_ovf SHALL hold their values between strobes.
REQ-023 The first gap after SYNC is partial and SHALL NOT be reported; a pulse high at reset release is partial and SHALL NOT be measured or counted.
REQ-024 Saturated counters SHALL stay at 2^WIDTH-1 until reloaded; no wrap.

Reset
REQ-025 rst=1 SHALL force state SYNC on the next edge, overriding d, with any measurement in progress discarded.
REQ-026 During/after reset: width=0, gap=0, width_valid=0, gap_valid=0, width_ovf=0, gap_ovf=0, pulses=0, first flag=1, internal counters=0.
REQ-027 The first edge with rst=0 SHALL evaluate d per the SYNC rules.

Verification
REQ-028 Reset then d=0 for 400 cycles, d=1 for 1 cycle, d=0 for 64 cycles, d=1 for 1 cycle -> width_valid with width=1 after first pulse; no gap_valid on first rise; gap_valid with gap=64 on second rise; pulses=2.
REQ-029 Repeated 1-high/j-low pattern, j=1..32 -> each gap_valid reports gap=j; each width_valid reports width=1.
REQ-030 1-high, 0-low, 1-high (j=0 case) -> a single width_valid with width=2; pulses increments once.
REQ-031 WIDTH=4: d high 20 cycles -> width=15, width_ovf=1; then low 3, high 1 -> gap=3, gap_ovf=0; low 16 then high -> gap=15, gap_ovf=1.
REQ-032 Release reset with d=1 held for 10 cycles, then low 5, high 2, low -> no strobe for the partial pulse; no gap_valid for the 5-cycle gap; width=2; pulses=1.
REQ-033 Assert rst mid-HIGH (after 5 high samples) for 1 cycle with d held high -> all outputs 0, no width_valid when d falls, next full pulse measured correctly.

Source files
------------

// File: rtl/pulse_measure.sv
// Pulse train measurement: width and gap of completed pulses,
// with saturation flags and a rising-edge count.
module pulse_measure #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  output logic [WIDTH-1:0] width,
  output logic             width_valid,
  output logic             width_ovf,
  output logic [WIDTH-1:0] gap,
  output logic             gap_valid,
  output logic             gap_ovf,
  output logic [15:0]      pulses
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  typedef enum logic [1:0] {
    SYNC,
    LOW,
    HIGH
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] wcnt, wcnt_n;
  logic [WIDTH-1:0] gcnt, gcnt_n;
  logic             wof, wof_n;
  logic             gof, gof_n;
  logic             first, first_n;
  logic [WIDTH-1:0] width_n, gap_n;
  logic             width_valid_n, gap_valid_n;
  logic             width_ovf_n, gap_ovf_n;
  logic [15:0]      pulses_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SYNC;
      wcnt        <= '0;
      gcnt        <= '0;
      wof         <= 1'b0;
      gof         <= 1'b0;
      first       <= 1'b1;
      width       <= '0;
      gap         <= '0;
      width_valid <= 1'b0;
      gap_valid   <= 1'b0;
      width_ovf   <= 1'b0;
      gap_ovf     <= 1'b0;
      pulses      <= '0;
    end else begin
      state       <= state_n;
      wcnt        <= wcnt_n;
      gcnt        <= gcnt_n;
      wof         <= wof_n;
      gof         <= gof_n;
      first       <= first_n;
      width       <= width_n;
      gap         <= gap_n;
      width_valid <= width_valid_n;
      gap_valid   <= gap_valid_n;
      width_ovf   <= width_ovf_n;
      gap_ovf     <= gap_ovf_n;
      pulses      <= pulses_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      SYNC:    if (!d) state_n = LOW;
      LOW:     if (d) state_n = HIGH;
      HIGH:    if (!d) state_n = LOW;
      default: state_n = SYNC;
    endcase
  end

  always_comb begin
    wcnt_n        = wcnt;
    gcnt_n        = gcnt;
    wof_n         = wof;
    gof_n         = gof;
    first_n       = first;
    width_n       = width;
    gap_n         = gap;
    width_ovf_n   = width_ovf;
    gap_ovf_n     = gap_ovf;
    width_valid_n = 1'b0;
    gap_valid_n   = 1'b0;
    pulses_n      = pulses;
    unique case (state)
      SYNC: begin
        if (!d) begin
          gcnt_n  = ONE;
          gof_n   = 1'b0;
          first_n = 1'b1;
        end
      end
      LOW: begin
        if (d) begin
          wcnt_n   = ONE;
          wof_n    = 1'b0;
          pulses_n = pulses + 16'd1;
          first_n  = 1'b0;
          // the low run seen right after sync is partial
          if (!first) begin
            gap_n       = gcnt;
            gap_ovf_n   = gof;
            gap_valid_n = 1'b1;
          end
        end else if (gcnt == CNT_MAX) begin
          gof_n = 1'b1;
        end else begin
          gcnt_n = gcnt + ONE;
        end
      end
      HIGH: begin
        if (!d) begin
          width_n       = wcnt;
          width_ovf_n   = wof;
          width_valid_n = 1'b1;
          gcnt_n        = ONE;
          gof_n         = 1'b0;
        end else if (wcnt == CNT_MAX) begin
          wof_n = 1'b1;
        end else begin
          wcnt_n = wcnt + ONE;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pulse_measure.sv
// Bench for pulse_measure: WIDTH=16 and WIDTH=4 instances share one
// stimulus stream, checked against a run-length reference model.
module tb_pulse_measure;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        d   = 1'b0;

  logic [15:0] wa [2];
  logic [15:0] ga [2];
  logic [3:0]  w4, g4;
  logic        wv [2];
  logic        gv [2];
  logic        wo [2];
  logic        go [2];
  logic [15:0] pa [2];

  always #5 clk = ~clk;

  pulse_measure #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .d(d),
    .width(wa[0]), .width_valid(wv[0]), .width_ovf(wo[0]),
    .gap(ga[0]), .gap_valid(gv[0]), .gap_ovf(go[0]),
    .pulses(pa[0])
  );

  pulse_measure #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .d(d),
    .width(w4), .width_valid(wv[1]), .width_ovf(wo[1]),
    .gap(g4), .gap_valid(gv[1]), .gap_ovf(go[1]),
    .pulses(pa[1])
  );

  assign wa[1] = {12'b0, w4};
  assign ga[1] = {12'b0, g4};

  typedef struct {
    int pulses;
    bit clr;
  } cyc_t;

  cyc_t  cq[$];
  int    wq[$];
  int    gq[$];
  int    vectors = 0;
  int    miscompares = 0;
  longint mx [2] = '{65535, 15};

  // reference model state: runs of equal samples since sync
  bit synced = 0;
  bit lvl = 0;
  int run_len = 0;
  bit first_low = 1;
  int exp_pulses = 0;

  task automatic chk(string nm, int k, longint act, longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s inst%0d: got %0d expected %0d at %0t",
               nm, k, act, exp, $time);
    end
  endtask

  task automatic model(bit dd, bit rr);
    if (rr) begin
      synced     = 0;
      exp_pulses = 0;
    end else if (!synced) begin
      if (!dd) begin
        synced    = 1;
        lvl       = 0;
        run_len   = 1;
        first_low = 1;
      end
    end else if (dd == lvl) begin
      run_len++;
    end else begin
      if (lvl) wq.push_back(run_len);
      else begin
        if (!first_low) gq.push_back(run_len);
        exp_pulses = (exp_pulses + 1) % 65536;
        first_low  = 0;
      end
      lvl     = dd;
      run_len = 1;
    end
    cq.push_back('{exp_pulses, rr});
  endtask

  task automatic step(bit dd, bit rr);
    d   = dd;
    rst = rr;
    @(posedge clk);
    model(dd, rr);
    #1;
  endtask

  task automatic run(bit v, int n);
    repeat (n) step(v, 1'b0);
  endtask

  longint lw [2] = '{0, 0};
  longint lg [2] = '{0, 0};
  bit     lwo [2] = '{0, 0};
  bit     lgo [2] = '{0, 0};

  always @(negedge clk) begin
    cyc_t c;
    bit   hw, hg;
    int   lw_raw, lg_raw;
    if (cq.size() != 0) begin
      c      = cq.pop_front();
      hw     = wq.size() != 0;
      hg     = gq.size() != 0;
      lw_raw = hw ? wq.pop_front() : 0;
      lg_raw = hg ? gq.pop_front() : 0;
      for (int k = 0; k < 2; k++) begin
        if (c.clr) begin
          lw[k] = 0; lwo[k] = 0;
          lg[k] = 0; lgo[k] = 0;
        end
        if (hw) begin
          lw[k]  = (lw_raw > mx[k]) ? mx[k] : lw_raw;
          lwo[k] = lw_raw > mx[k];
        end
        if (hg) begin
          lg[k]  = (lg_raw > mx[k]) ? mx[k] : lg_raw;
          lgo[k] = lg_raw > mx[k];
        end
        chk("width_valid", k, wv[k], hw);
        chk("gap_valid", k, gv[k], hg);
        chk("width", k, wa[k], lw[k]);
        chk("width_ovf", k, wo[k], lwo[k]);
        chk("gap", k, ga[k], lg[k]);
        chk("gap_ovf", k, go[k], lgo[k]);
        chk("pulses", k, pa[k], c.pulses);
        chk("both_valid", k, wv[k] && gv[k], 0);
      end
    end
  end

  initial begin
    bit lv;
    int n;
    repeat (2) step(1'b0, 1'b1);
    run(0, 400); run(1, 1); run(0, 64); run(1, 1); run(0, 3);
    for (int j = 1; j <= 32; j++) begin
      run(1, 1);
      run(0, j);
    end
    run(1, 2); run(0, 2);
    run(1, 20); run(0, 3); run(1, 1); run(0, 16); run(1, 1); run(0, 2);
    step(1'b1, 1'b1);
    run(1, 10); run(0, 5); run(1, 2); run(0, 3);
    step(1'b0, 1'b1);
    run(0, 4); run(1, 1); run(0, 3); run(1, 5);
    step(1'b1, 1'b1);
    run(1, 4); run(0, 3); run(1, 6); run(0, 4);
    lv = 1'b1;
    repeat (250) begin
      if ($urandom_range(0, 15) == 0)
        step(1'($urandom_range(0, 1)), 1'b1);
      if ($urandom_range(0, 7) == 0) n = $urandom_range(14, 40);
      else n = $urandom_range(1, 6);
      run(lv, n);
      lv = !lv;
    end
    run(0, 2);
    @(negedge clk);
    #1;
    chk("drain", 0, cq.size() + wq.size() + gq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
